priority_encoder8to3_reg: RTL and testbench

PRIORITY_ENCODER8TO3_REG -- requirements
Module: priority_encoder8to3_reg

---
 rtl/priority_encoder8to3_reg.sv | 105 ++++++++++
 tb/tb_priority_encoder8to3_reg.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder8to3_reg.sv
// Registered 8-to-3 priority encoder with a pending-request register and a
// present/acknowledge handshake. A request stays pending until the consumer
// acknowledges it while it is presented on y; pending requests are served one
// per acknowledged cycle in fixed priority order, and a presented index is
// never preempted by a later higher-priority arrival.
module priority_encoder8to3_reg #(
  parameter int LSB_FIRST = 0  // 0: bit 7 has highest priority, 1: bit 0 does
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] d,
  input  logic       ack,
  output logic [2:0] y,
  output logic       valid,
  output logic       multi,
  output logic [7:0] pend
);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] clr;
  logic [7:0] nxt_pend;

  // Index of the highest-priority set bit; the later loop assignment wins, so
  // the scan direction sets the priority order. Callers only pass nonzero v.
  function automatic logic [2:0] pick_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (LSB_FIRST != 0) begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // True when more than one bit is set: clearing the lowest set bit leaves
  // something behind.
  function automatic logic more_than_one(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'h00;
  endfunction

  // Clear mask and next pending value; new requests are ORed in after the
  // clear so a same-edge re-request keeps the bit pending.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment so
    // no path leaves it unassigned, which would otherwise infer a latch.
    clr = 8'h00;
    if (valid && ack) clr[y] = 1'b1;
    nxt_pend = (pend & ~clr) | (en ? d : 8'h00);
  end

  // Pending register and IDLE/SHOW presentation FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pend  <= 8'h00;
      y     <= 3'd0;
      valid <= 1'b0;
      multi <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      pend <= nxt_pend;
      case (state)
        IDLE: begin
          // Present from the registered pending set; y/multi hold when empty.
          if (pend != 8'h00) begin
            state <= SHOW;
            valid <= 1'b1;
            y     <= pick_index(pend);
            multi <= more_than_one(pend);
          end
        end
        SHOW: begin
          // Without ack everything holds; with ack move straight to the next
          // pending request so there is no idle bubble between presentations.
          if (ack) begin
            if (nxt_pend != 8'h00) begin
              y     <= pick_index(nxt_pend);
              multi <= more_than_one(nxt_pend);
            end else begin
              state <= IDLE;
              valid <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_encoder8to3_reg.sv
// Testbench for priority_encoder8to3_reg: directed scenarios with constant
// expectations, then randomized traffic against a set-based reference model.
// Two instances share stimulus, one per priority order.
module tb_priority_encoder8to3_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] d   = 8'h00;
  logic       ack = 1'b0;

  logic [2:0] y0, y1;
  logic       valid0, valid1, multi0, multi1;
  logic [7:0] pend0, pend1;
  logic [12:0] obs0, obs1;

  int n_checks = 0;
  int n_pass   = 0;

  assign obs0 = {valid0, y0, multi0, pend0};
  assign obs1 = {valid1, y1, multi1, pend1};

  always #5 clk = ~clk;

  priority_encoder8to3_reg #(.LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst(rst), .en(en), .d(d), .ack(ack),
    .y(y0), .valid(valid0), .multi(multi0), .pend(pend0)
  );

  priority_encoder8to3_reg #(.LSB_FIRST(1)) dut_lsb (
    .clk(clk), .rst(rst), .en(en), .d(d), .ack(ack),
    .y(y1), .valid(valid1), .multi(multi1), .pend(pend1)
  );

  // Expected {valid, y, multi, pend} packed for comparison.
  function automatic logic [12:0] pack(input logic v, input int yy, input logic m,
                                       input logic [7:0] p);
    return {v, 3'(yy), m, p};
  endfunction

  function automatic void put(input logic e, input logic [7:0] dd, input logic a);
    en  = e;
    d   = dd;
    ack = a;
  endfunction

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    put(1'b1, 8'hFF, 1'b1);
    step();
    step();
    n_checks++;
    if (obs0 !== pack(0, 0, 0, 8'h00)) $display("FAIL reset_msb: got %h expected %h", obs0, pack(0, 0, 0, 8'h00));
    else n_pass++;
    n_checks++;
    if (obs1 !== pack(0, 0, 0, 8'h00)) $display("FAIL reset_lsb: got %h expected %h", obs1, pack(0, 0, 0, 8'h00));
    else n_pass++;
    put(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    step();
    n_checks++;
    if (obs0 !== pack(0, 0, 0, 8'h00)) $display("FAIL reset_release: got %h expected %h", obs0, pack(0, 0, 0, 8'h00));
    else n_pass++;
  endtask

  task automatic test_single();
    put(1'b1, 8'h20, 1'b0);
    step();
    n_checks++;
    if (obs0 !== pack(0, 0, 0, 8'h20)) $display("FAIL single_capture: got %h expected %h", obs0, pack(0, 0, 0, 8'h20));
    else n_pass++;
    put(1'b0, 8'h00, 1'b0);
    step();
    n_checks++;
    if (obs0 !== pack(1, 5, 0, 8'h20)) $display("FAIL single_show: got %h expected %h", obs0, pack(1, 5, 0, 8'h20));
    else n_pass++;
    repeat (4) step();
    n_checks++;
    if (obs0 !== pack(1, 5, 0, 8'h20)) $display("FAIL single_hold: got %h expected %h", obs0, pack(1, 5, 0, 8'h20));
    else n_pass++;
    put(1'b0, 8'h00, 1'b1);
    step();
    n_checks++;
    if (obs0 !== pack(0, 5, 0, 8'h00)) $display("FAIL single_ack: got %h expected %h", obs0, pack(0, 5, 0, 8'h00));
    else n_pass++;
    put(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    put(1'b1, 8'h81, 1'b1);
    step();
    n_checks++;
    if (obs0 !== pack(0, 5, 0, 8'h81)) $display("FAIL b2b_capture: got %h expected %h", obs0, pack(0, 5, 0, 8'h81));
    else n_pass++;
    put(1'b0, 8'h00, 1'b1);
    step();
    n_checks++;
    if (obs0 !== pack(1, 7, 1, 8'h81)) $display("FAIL b2b_first: got %h expected %h", obs0, pack(1, 7, 1, 8'h81));
    else n_pass++;
    step();
    n_checks++;
    if (obs0 !== pack(1, 0, 0, 8'h01)) $display("FAIL b2b_second: got %h expected %h", obs0, pack(1, 0, 0, 8'h01));
    else n_pass++;
    step();
    n_checks++;
    if (obs0 !== pack(0, 0, 0, 8'h00)) $display("FAIL b2b_done: got %h expected %h", obs0, pack(0, 0, 0, 8'h00));
    else n_pass++;
    put(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_no_preempt();
    put(1'b1, 8'h02, 1'b0);
    step();
    put(1'b0, 8'h00, 1'b0);
    step();
    put(1'b1, 8'h80, 1'b0);
    step();
    put(1'b0, 8'h00, 1'b0);
    step();
    n_checks++;
    if (obs0 !== pack(1, 1, 0, 8'h82)) $display("FAIL preempt_hold: got %h expected %h", obs0, pack(1, 1, 0, 8'h82));
    else n_pass++;
    put(1'b0, 8'h00, 1'b1);
    step();
    n_checks++;
    if (obs0 !== pack(1, 7, 0, 8'h80)) $display("FAIL preempt_next: got %h expected %h", obs0, pack(1, 7, 0, 8'h80));
    else n_pass++;
    step();
    n_checks++;
    if (obs0 !== pack(0, 7, 0, 8'h00)) $display("FAIL preempt_done: got %h expected %h", obs0, pack(0, 7, 0, 8'h00));
    else n_pass++;
    put(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_same_edge();
    put(1'b1, 8'h08, 1'b0);
    step();
    put(1'b0, 8'h00, 1'b0);
    step();
    put(1'b1, 8'h08, 1'b1);
    step();
    n_checks++;
    if (obs0 !== pack(1, 3, 0, 8'h08)) $display("FAIL same_edge_set: got %h expected %h", obs0, pack(1, 3, 0, 8'h08));
    else n_pass++;
    put(1'b0, 8'h00, 1'b1);
    step();
    n_checks++;
    if (obs0 !== pack(0, 3, 0, 8'h00)) $display("FAIL same_edge_clear: got %h expected %h", obs0, pack(0, 3, 0, 8'h00));
    else n_pass++;
    put(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_idle_ack();
    put(1'b0, 8'h00, 1'b1);
    step();
    n_checks++;
    if (obs0 !== pack(0, 3, 0, 8'h00)) $display("FAIL idle_ack: got %h expected %h", obs0, pack(0, 3, 0, 8'h00));
    else n_pass++;
    put(1'b1, 8'h01, 1'b0);
    step();
    put(1'b0, 8'h00, 1'b0);
    step();
    n_checks++;
    if (obs0 !== pack(1, 0, 0, 8'h01)) $display("FAIL index_zero: got %h expected %h", obs0, pack(1, 0, 0, 8'h01));
    else n_pass++;
    put(1'b0, 8'h00, 1'b1);
    step();
    put(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid();
    put(1'b1, 8'hFF, 1'b0);
    step();
    put(1'b0, 8'h00, 1'b0);
    step();
    n_checks++;
    if (obs0 !== pack(1, 7, 1, 8'hFF)) $display("FAIL mid_before: got %h expected %h", obs0, pack(1, 7, 1, 8'hFF));
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs0 !== pack(0, 0, 0, 8'h00)) $display("FAIL mid_async_msb: got %h expected %h", obs0, pack(0, 0, 0, 8'h00));
    else n_pass++;
    n_checks++;
    if (obs1 !== pack(0, 0, 0, 8'h00)) $display("FAIL mid_async_lsb: got %h expected %h", obs1, pack(0, 0, 0, 8'h00));
    else n_pass++;
    put(1'b1, 8'hFF, 1'b1);
    step();
    put(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    step();
    step();
    n_checks++;
    if (obs0 !== pack(0, 0, 0, 8'h00)) $display("FAIL mid_after: got %h expected %h", obs0, pack(0, 0, 0, 8'h00));
    else n_pass++;
  endtask

  task automatic test_lsb_first();
    put(1'b1, 8'h90, 1'b1);
    step();
    put(1'b0, 8'h00, 1'b1);
    step();
    n_checks++;
    if (obs1 !== pack(1, 4, 1, 8'h90)) $display("FAIL lsb_first: got %h expected %h", obs1, pack(1, 4, 1, 8'h90));
    else n_pass++;
    n_checks++;
    if (obs0 !== pack(1, 7, 1, 8'h90)) $display("FAIL msb_first: got %h expected %h", obs0, pack(1, 7, 1, 8'h90));
    else n_pass++;
    step();
    n_checks++;
    if (obs1 !== pack(1, 7, 0, 8'h80)) $display("FAIL lsb_second: got %h expected %h", obs1, pack(1, 7, 0, 8'h80));
    else n_pass++;
    n_checks++;
    if (obs0 !== pack(1, 4, 0, 8'h10)) $display("FAIL msb_second: got %h expected %h", obs0, pack(1, 4, 0, 8'h10));
    else n_pass++;
    step();
    n_checks++;
    if (obs1 !== pack(0, 7, 0, 8'h00)) $display("FAIL lsb_done: got %h expected %h", obs1, pack(0, 7, 0, 8'h00));
    else n_pass++;
    put(1'b0, 8'h00, 1'b0);
  endtask

  // First pending request in priority order, found by walking the order list.
  function automatic int ref_pick(input logic [7:0] p, input bit lsb);
    int order[8];
    for (int k = 0; k < 8; k++) order[k] = lsb ? k : 7 - k;
    foreach (order[k]) if (p[order[k]]) return order[k];
    return 0;
  endfunction

  task automatic test_random();
    logic [7:0] m_pend[2];
    logic       m_valid[2];
    int         m_y[2];
    logic       m_multi[2];
    logic [7:0] nxt;
    logic [12:0] got;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      m_pend[u] = 8'h00; m_valid[u] = 1'b0; m_y[u] = 0; m_multi[u] = 1'b0;
    end
    for (int c = 0; c < 400; c++) begin
      put($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 1) == 1);
      for (int u = 0; u < 2; u++) begin
        nxt = m_pend[u];
        if (m_valid[u] && ack) nxt[m_y[u]] = 1'b0;
        if (en) nxt = nxt | d;
        if (!m_valid[u]) begin
          if (m_pend[u] != 8'h00) begin
            m_valid[u] = 1'b1;
            m_y[u]     = ref_pick(m_pend[u], u == 1);
            m_multi[u] = $countones(m_pend[u]) > 1;
          end
        end else if (ack) begin
          if (nxt != 8'h00) begin
            m_y[u]     = ref_pick(nxt, u == 1);
            m_multi[u] = $countones(nxt) > 1;
          end else begin
            m_valid[u] = 1'b0;
          end
        end
        m_pend[u] = nxt;
      end
      step();
      for (int u = 0; u < 2; u++) begin
        got = (u == 0) ? obs0 : obs1;
        n_checks++;
        if (got !== pack(m_valid[u], m_y[u], m_multi[u], m_pend[u]))
          $display("FAIL random_%0d cycle %0d: got %h expected %h", u, c, got,
                   pack(m_valid[u], m_y[u], m_multi[u], m_pend[u]));
        else n_pass++;
      end
    end
    put(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_no_preempt();
    test_same_edge();
    test_idle_ack();
    test_reset_mid();
    test_lsb_first();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
